// File: rtl/branch_predictor_table_if.sv
// Fetch-side lookup and resolve-side update bundle for the branch predictor table.
// The master drives requests/resolve data; the slave (the predictor) returns predictions and stats.
interface branch_predictor_table_if #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned CNT_W = 32
);
    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_index;

    logic             res_valid;
    logic [31:0]      res_inst;
    logic             res_eq;
    logic             res_lt;
    logic             res_ltu;
    logic [IDX_W-1:0] res_index;
    logic             res_pred_taken;
    logic             res_taken;
    logic             res_mispredict;

    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output pred_valid, pred_pc,
        output res_valid, res_inst, res_eq, res_lt, res_ltu, res_index, res_pred_taken,
        input  pred_taken, pred_index, res_taken, res_mispredict,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  pred_valid, pred_pc,
        input  res_valid, res_inst, res_eq, res_lt, res_ltu, res_index, res_pred_taken,
        output pred_taken, pred_index, res_taken, res_mispredict,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_table.sv
// PC-indexed table of saturating counters with optional gshare history, RV32I branch
// resolution, misprediction flagging and branch/mispredict statistics.
module branch_predictor_table #(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned GHR_BITS = 0,
    parameter int unsigned CNT_W    = 32
) (
    input logic clk,
    input logic rst,
    branch_predictor_table_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CtrMax = '1;
    localparam logic [CTR_BITS-1:0] CtrMin = '0;
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [CNT_W-1:0]    branch_count_q;
    logic [CNT_W-1:0]    mispredict_count_q;

    logic [IDX_W-1:0] pc_idx;
    logic [IDX_W-1:0] hist;
    logic [IDX_W-1:0] idx;
    logic [2:0]       funct3;
    logic             is_br;
    logic             taken;
    logic             mispredict;
    logic             unused_bits;

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    assign pc_idx = bus.pred_pc[IDX_W+1:2];
    assign idx    = pc_idx ^ hist;

    assign bus.pred_index = idx;
    assign bus.pred_taken = bus.pred_valid & ctr_q[idx][CTR_BITS-1];

    assign funct3 = bus.res_inst[14:12];

    always_comb begin
        is_br = bus.res_valid && (bus.res_inst[6:0] == OpBranch) &&
                (funct3 != 3'b010) && (funct3 != 3'b011);
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = bus.res_eq;
            3'b001:  taken = !bus.res_eq;
            3'b100:  taken = bus.res_lt;
            3'b101:  taken = !bus.res_lt;
            3'b110:  taken = bus.res_ltu;
            3'b111:  taken = !bus.res_ltu;
            default: taken = 1'b0;
        endcase
        if (!is_br) begin
            taken = 1'b0;
        end
    end

    assign mispredict         = is_br && (taken != bus.res_pred_taken);
    assign bus.res_taken      = taken;
    assign bus.res_mispredict = mispredict;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                ctr_q[i] <= CtrInit;
            end
        end else if (is_br) begin
            if (taken && (ctr_q[bus.res_index] != CtrMax)) begin
                ctr_q[bus.res_index] <= ctr_q[bus.res_index] + 1'b1;
            end else if (!taken && (ctr_q[bus.res_index] != CtrMin)) begin
                ctr_q[bus.res_index] <= ctr_q[bus.res_index] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (is_br) begin
            branch_count_q     <= branch_count_q + 1'b1;
            mispredict_count_q <= mispredict_count_q + CNT_W'(mispredict);
        end
    end

    assign bus.branch_count     = branch_count_q;
    assign bus.mispredict_count = mispredict_count_q;

    // History is shifted only on resolved branches, so it is non-speculative.
    if (GHR_BITS > 0) begin : gen_gshare
        logic [GHR_BITS-1:0] ghr_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                ghr_q <= '0;
            end else if (is_br) begin
                ghr_q <= GHR_BITS'({ghr_q, taken});
            end
        end

        assign hist = IDX_W'(ghr_q);
    end else begin : gen_bimodal
        assign hist = '0;
    end

    assign unused_bits = ^{bus.pred_pc, bus.res_inst};
endmodule

// File: tb/tb_branch_predictor_table.sv
// Bench for branch_predictor_table: a bimodal and a gshare instance driven in lockstep and
// checked against an array-based reference model plus directed corner sequences.
module tb_branch_predictor_table;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_table_if #(.IDX_W(4), .CNT_W(32)) bus0 ();
    branch_predictor_table_if #(.IDX_W(4), .CNT_W(32)) bus1 ();

    branch_predictor_table #(.ENTRIES(16), .CTR_BITS(2), .GHR_BITS(0), .CNT_W(32)) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    branch_predictor_table #(.ENTRIES(16), .CTR_BITS(2), .GHR_BITS(2), .CNT_W(32)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    int total = 0;
    int bad = 0;

    logic        pv;
    logic [31:0] pc;
    logic        rv;
    logic [31:0] inst;
    logic        eq, lt, ltu, ptk;
    logic [3:0]  ridx;

    // Reference model: counters as plain integers, history as an integer shift register.
    int          m_ctr[2][16];
    int          m_ghr;
    int unsigned m_bc;
    int unsigned m_mc;

    typedef struct {
        logic [31:0] inst;
        logic        exp_taken;
        logic        counts;
    } vec_t;
    vec_t vt[8];

    localparam logic [31:0] Beq = 32'h00208063;

    function automatic int m_idx(int d, logic [31:0] p);
        int base = int'((p >> 2) & 32'hF);
        if (d == 1) return base ^ m_ghr;
        return base;
    endfunction

    function automatic bit m_is_br();
        int f3 = int'(inst[14:12]);
        return rv && (inst[6:0] == 7'h63) && (f3 != 2) && (f3 != 3);
    endfunction

    function automatic bit m_taken();
        if (!m_is_br()) return 1'b0;
        case (int'(inst[14:12]))
            0: return eq;
            1: return !eq;
            4: return lt;
            5: return !lt;
            6: return ltu;
            7: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_one(string tag, int d, logic ptk_o, logic [3:0] idx_o, logic rtk_o,
                             logic mis_o, logic [31:0] bc_o, logic [31:0] mc_o);
        bit br = m_is_br();
        bit tk = m_taken();
        int i = m_idx(d, pc);
        chk({tag, "_pred_index"}, idx_o, i);
        chk({tag, "_pred_taken"}, ptk_o, (pv && m_ctr[d][i] >= 2) ? 1 : 0);
        chk({tag, "_res_taken"}, rtk_o, tk);
        chk({tag, "_res_mispredict"}, mis_o, (br && (tk != ptk)) ? 1 : 0);
        chk({tag, "_branch_count"}, bc_o, m_bc);
        chk({tag, "_mispredict_count"}, mc_o, m_mc);
    endtask

    task automatic drive();
        bus0.pred_valid = pv;  bus1.pred_valid = pv;
        bus0.pred_pc = pc;     bus1.pred_pc = pc;
        bus0.res_valid = rv;   bus1.res_valid = rv;
        bus0.res_inst = inst;  bus1.res_inst = inst;
        bus0.res_eq = eq;      bus1.res_eq = eq;
        bus0.res_lt = lt;      bus1.res_lt = lt;
        bus0.res_ltu = ltu;    bus1.res_ltu = ltu;
        bus0.res_index = ridx; bus1.res_index = ridx;
        bus0.res_pred_taken = ptk;
        bus1.res_pred_taken = ptk;
    endtask

    task automatic sample(bit en);
        drive();
        @(negedge clk);
        if (en) begin
            check_one("d0", 0, bus0.pred_taken, bus0.pred_index, bus0.res_taken,
                      bus0.res_mispredict, bus0.branch_count, bus0.mispredict_count);
            check_one("d1", 1, bus1.pred_taken, bus1.pred_index, bus1.res_taken,
                      bus1.res_mispredict, bus1.branch_count, bus1.mispredict_count);
        end
    endtask

    task automatic advance();
        bit br = m_is_br();
        bit tk = m_taken();
        @(posedge clk);
        if (rst) begin
            for (int d = 0; d < 2; d++)
                for (int i = 0; i < 16; i++) m_ctr[d][i] = 1;
            m_ghr = 0;
            m_bc = 0;
            m_mc = 0;
        end else if (br) begin
            for (int d = 0; d < 2; d++) begin
                if (tk) m_ctr[d][ridx] = (m_ctr[d][ridx] < 3) ? m_ctr[d][ridx] + 1 : 3;
                else    m_ctr[d][ridx] = (m_ctr[d][ridx] > 0) ? m_ctr[d][ridx] - 1 : 0;
            end
            m_ghr = ((m_ghr << 1) | int'(tk)) & 3;
            m_bc++;
            if (tk != ptk) m_mc++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rv = 1'b0;
        sample(1'b1);
        advance();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1; pv = 1'b1; pc = 32'h40; rv = 1'b0; inst = 32'h0;
        eq = 1'b0; lt = 1'b0; ltu = 1'b0; ptk = 1'b0; ridx = 4'd0;
        m_ghr = 0; m_bc = 0; m_mc = 0;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) m_ctr[d][i] = 0;

        // Reset state
        sample(1'b0);
        advance();
        rst = 1'b0;
        sample(1'b1);
        chk("reset_pred_index", bus0.pred_index, 0);
        chk("reset_pred_taken", bus0.pred_taken, 0);
        chk("reset_branch_count", bus0.branch_count, 0);
        chk("reset_mispredict_count", bus0.mispredict_count, 0);
        advance();

        // Four taken BEQs into index 0: counter 1->2->3->3
        rv = 1'b1; inst = Beq; eq = 1'b1; ridx = 4'd0; ptk = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample(1'b1);
            chk("beq_pred_taken", bus0.pred_taken, (k >= 1) ? 1 : 0);
            chk("beq_mispredict", bus0.res_mispredict, 1);
            advance();
        end
        rv = 1'b0;
        sample(1'b1);
        chk("beq_branch_count", bus0.branch_count, 4);
        chk("beq_mispredict_count", bus0.mispredict_count, 4);
        chk("beq_saturated_pred", bus0.pred_taken, 1);
        advance();
        pc = 32'h04;
        sample(1'b1);
        chk("gshare_index", bus1.pred_index, 2);
        advance();

        // Funct3 sweep on index 5 with eq=0 lt=1 ltu=0
        do_reset();
        vt[0] = '{{17'h0, 3'b000, 5'h0, 7'h63}, 1'b0, 1'b1};
        vt[1] = '{{17'h0, 3'b001, 5'h0, 7'h63}, 1'b1, 1'b1};
        vt[2] = '{{17'h0, 3'b100, 5'h0, 7'h63}, 1'b1, 1'b1};
        vt[3] = '{{17'h0, 3'b101, 5'h0, 7'h63}, 1'b0, 1'b1};
        vt[4] = '{{17'h0, 3'b110, 5'h0, 7'h63}, 1'b0, 1'b1};
        vt[5] = '{{17'h0, 3'b111, 5'h0, 7'h63}, 1'b1, 1'b1};
        vt[6] = '{{17'h0, 3'b010, 5'h0, 7'h63}, 1'b0, 1'b0};
        vt[7] = '{{17'h0, 3'b000, 5'h0, 7'h33}, 1'b0, 1'b0};
        rv = 1'b1; eq = 1'b0; lt = 1'b1; ltu = 1'b0; ridx = 4'd5; ptk = 1'b0;
        for (int i = 0; i < 8; i++) begin
            inst = vt[i].inst;
            sample(1'b1);
            chk($sformatf("sweep%0d_res_taken", i), bus0.res_taken, vt[i].exp_taken);
            chk($sformatf("sweep%0d_mispredict", i), bus0.res_mispredict,
                (vt[i].counts && vt[i].exp_taken) ? 1 : 0);
            advance();
        end
        rv = 1'b0;
        sample(1'b1);
        chk("sweep_branch_count", bus0.branch_count, 6);
        chk("sweep_mispredict_count", bus0.mispredict_count, 3);
        advance();

        // Same-cycle lookup/update of index 3: no bypass
        do_reset();
        pv = 1'b1; pc = 32'h0C; rv = 1'b1; inst = Beq; eq = 1'b1; ridx = 4'd3; ptk = 1'b0;
        sample(1'b1);
        chk("hazard_same_cycle", bus0.pred_taken, 0);
        advance();
        rv = 1'b0;
        sample(1'b1);
        chk("hazard_next_cycle", bus0.pred_taken, 1);
        advance();

        // Reset asserted together with a branch update
        rv = 1'b1; inst = Beq; eq = 1'b1; ridx = 4'd7;
        for (int k = 0; k < 2; k++) begin
            sample(1'b1);
            advance();
        end
        rst = 1'b1;
        sample(1'b1);
        advance();
        rst = 1'b0; rv = 1'b0;
        sample(1'b1);
        chk("midrst_branch_count", bus0.branch_count, 0);
        chk("midrst_mispredict_count", bus0.mispredict_count, 0);
        advance();
        // One taken update per entry must lift every entry from 1 to 2
        for (int i = 0; i <= 16; i++) begin
            rv = (i < 16); inst = Beq; eq = 1'b1; ridx = 4'(i);
            pv = (i >= 1); pc = (i >= 1) ? 32'((i - 1) * 4) : 32'h0;
            sample(1'b1);
            if (i >= 1) chk($sformatf("midrst_entry%0d", i - 1), bus0.pred_taken, 1);
            advance();
        end

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            pv = 1'($urandom_range(0, 1));
            pc = $urandom;
            r = $urandom;
            inst = ($urandom_range(0, 3) != 0) ? {r[31:7], 7'h63} : r;
            rv = ($urandom_range(0, 7) != 0);
            eq = 1'($urandom_range(0, 1));
            lt = 1'($urandom_range(0, 1));
            ltu = 1'($urandom_range(0, 1));
            ptk = 1'($urandom_range(0, 1));
            ridx = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            sample(1'b1);
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
